// File: rtl/button_bounce_gen.sv
// Synthetic mechanical-button waveform source (edge, LFSR-timed bounce glitches, stable settle).
// Line changes on the accept edge; one command in flight, cmd_valid must be held until cmd_ready.
module button_bounce_gen #(
    parameter int         BOUNCE_MAX = 7,
    parameter int         DWELL_W    = 4,
    parameter int         SETTLE_MS  = 20,
    parameter logic [7:0] SEED       = 8'hA5
) (
    input  logic       clk_1k,
    input  logic       rst,
    input  logic       cmd_valid,
    output logic       cmd_ready,
    input  logic       cmd_level,
    input  logic [2:0] cmd_bounces,
    output logic       button_out,
    output logic       busy,
    output logic       done
);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_BOUNCE_LO,
        ST_BOUNCE_HI,
        ST_SETTLE,
        ST_DONE
    } state_t;

    localparam logic [2:0] BMAX      = 3'((BOUNCE_MAX > 7) ? 7 : BOUNCE_MAX);
    localparam logic [7:0] SETTLE_LD = 8'(SETTLE_MS - 1);
    // Galois feedback mask for x^8+x^6+x^5+x^4+1 (right-shifting form)
    localparam logic [7:0] LFSR_TAPS = 8'hB8;

    state_t     state_q, state_d;
    logic [7:0] cnt_q, cnt_d;
    logic [2:0] n_q, n_d;
    logic       tgt_q, tgt_d;
    logic       btn_q, btn_d;
    logic [7:0] lfsr_q, lfsr_d;

    logic [7:0] dwell_m1;
    logic [2:0] n_req;

    // Counters hold "remaining cycles minus one", so expiry is simply cnt == 0
    assign dwell_m1 = 8'(lfsr_q[DWELL_W-1:0]);
    assign n_req    = (cmd_bounces > BMAX) ? BMAX : cmd_bounces;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        n_d     = n_q;
        tgt_d   = tgt_q;
        btn_d   = btn_q;
        lfsr_d  = {1'b0, lfsr_q[7:1]} ^ (lfsr_q[0] ? LFSR_TAPS : 8'h00);

        case (state_q)
            ST_IDLE: begin
                if (cmd_valid) begin
                    tgt_d = cmd_level;
                    btn_d = cmd_level;
                    n_d   = n_req;
                    if (n_req == 3'd0) begin
                        state_d = ST_SETTLE;
                        cnt_d   = SETTLE_LD;
                    end else begin
                        state_d = ST_BOUNCE_LO;
                        cnt_d   = dwell_m1;
                    end
                end
            end
            ST_BOUNCE_LO: begin
                if (cnt_q == 8'd0) begin
                    btn_d   = ~tgt_q;
                    cnt_d   = dwell_m1;
                    state_d = ST_BOUNCE_HI;
                end else begin
                    cnt_d = cnt_q - 8'd1;
                end
            end
            ST_BOUNCE_HI: begin
                if (cnt_q == 8'd0) begin
                    btn_d = tgt_q;
                    n_d   = n_q - 3'd1;
                    if (n_q == 3'd1) begin
                        state_d = ST_SETTLE;
                        cnt_d   = SETTLE_LD;
                    end else begin
                        state_d = ST_BOUNCE_LO;
                        cnt_d   = dwell_m1;
                    end
                end else begin
                    cnt_d = cnt_q - 8'd1;
                end
            end
            ST_SETTLE: begin
                if (cnt_q == 8'd0) begin
                    state_d = ST_DONE;
                end else begin
                    cnt_d = cnt_q - 8'd1;
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk_1k) begin
        if (rst) begin
            state_q <= ST_IDLE;
            cnt_q   <= 8'd0;
            n_q     <= 3'd0;
            tgt_q   <= 1'b0;
            btn_q   <= 1'b0;
            lfsr_q  <= SEED;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            n_q     <= n_d;
            tgt_q   <= tgt_d;
            btn_q   <= btn_d;
            lfsr_q  <= lfsr_d;
        end
    end

    assign button_out = btn_q;
    assign cmd_ready  = (state_q == ST_IDLE);
    assign busy       = (state_q != ST_IDLE);
    assign done       = (state_q == ST_DONE);

endmodule

// File: tb/tb_button_bounce_gen.sv
// Randomized bench for button_bounce_gen against a segment-list model of the button waveform.
module tb_button_bounce_gen;

    localparam int         BMAX   = 4;
    localparam int         DW     = 4;
    localparam int         SETTLE = 20;
    localparam logic [7:0] SEED   = 8'hA5;

    logic       clk_1k = 1'b0;
    logic       rst = 1'b1;
    logic       cmd_valid = 1'b0;
    logic       cmd_level = 1'b0;
    logic [2:0] cmd_bounces = 3'd0;
    logic       cmd_ready, button_out, busy, done;

    int   n_chk = 0;
    int   n_fail = 0;
    int   cyc = 0;
    int   rst_edge = 0;
    int   last_wait = 0;
    logic m_line = 1'b0;
    logic rec_q[$];
    logic rec1[$];

    button_bounce_gen #(
        .BOUNCE_MAX(BMAX),
        .DWELL_W   (DW),
        .SETTLE_MS (SETTLE),
        .SEED      (SEED)
    ) dut (
        .clk_1k     (clk_1k),
        .rst        (rst),
        .cmd_valid  (cmd_valid),
        .cmd_ready  (cmd_ready),
        .cmd_level  (cmd_level),
        .cmd_bounces(cmd_bounces),
        .button_out (button_out),
        .busy       (busy),
        .done       (done)
    );

    always #5 clk_1k = ~clk_1k;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    // One clock: inputs were set before the edge, outputs are looked at 1 time unit after it
    task automatic step();
        @(posedge clk_1k);
        cyc++;
        if (rst) rst_edge = cyc;
        #1;
    endtask

    // LFSR contents just before edge e: SEED advanced once per non-reset edge since the last reset
    function automatic logic [7:0] lfsr_at(input int e);
        logic [7:0] l;
        l = SEED;
        for (int i = 0; i < e - rst_edge - 1; i++)
            l = (l >> 1) ^ (l[0] ? 8'hB8 : 8'h00);
        return l;
    endfunction

    task automatic idle(input int ncyc);
        int act;
        act = 0;
        for (int i = 0; i < ncyc; i++) begin
            step();
            if (button_out !== m_line || busy !== 1'b0 || done !== 1'b0 || cmd_ready !== 1'b1)
                act++;
        end
        check("idle_quiet", 32'(act), 32'd0);
    endtask

    task automatic do_reset(input int ncyc);
        rst = 1'b1;
        cmd_valid = 1'b0;
        for (int i = 0; i < ncyc; i++) step();
        check("rst_button", 32'(button_out), 32'd0);
        check("rst_ready", 32'(cmd_ready), 32'd1);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        rst = 1'b0;
        m_line = 1'b0;
    endtask

    task automatic run_cmd(input logic lvl, input int nb, input bit queue_next, input bit abort);
        int   n, t, a, d, tog, wait_c, first_hi;
        logic [7:0] l;
        logic exp_lv[$];
        logic prev;
        cmd_valid   = 1'b1;
        cmd_level   = lvl;
        cmd_bounces = 3'(nb);
        wait_c = 0;
        while (cmd_ready !== 1'b1 && wait_c < 300) begin
            step();
            wait_c++;
        end
        last_wait = wait_c;
        check("ready_wait", 32'(cmd_ready), 32'd1);
        step();
        a = cyc;
        cmd_valid = 1'b0;

        // Expected line: 2n bounce segments of LFSR dwell, SETTLE cycles at target, one done cycle
        n = (nb > BMAX) ? BMAX : nb;
        t = a;
        first_hi = -1;
        for (int i = 0; i < 2 * n; i++) begin
            l = lfsr_at(t);
            d = (int'(l) % (1 << DW)) + 1;
            if (i == 1) first_hi = exp_lv.size();
            for (int j = 0; j < d; j++) exp_lv.push_back((i % 2 == 0) ? lvl : ~lvl);
            t += d;
        end
        for (int j = 0; j < SETTLE + 1; j++) exp_lv.push_back(lvl);

        rec_q.delete();
        tog = 0;
        prev = 1'b0;
        for (int k = 0; k < exp_lv.size(); k++) begin
            if (k > 0) step();
            if (abort && k == first_hi) begin
                rst = 1'b1;
                step();
                rst = 1'b0;
                check("abort_button", 32'(button_out), 32'd0);
                check("abort_busy", 32'(busy), 32'd0);
                check("abort_done", 32'(done), 32'd0);
                check("abort_ready", 32'(cmd_ready), 32'd1);
                m_line = 1'b0;
                idle(5);
                return;
            end
            check("line", 32'(button_out), 32'(exp_lv[k]));
            check("busy", 32'(busy), 32'd1);
            check("ready_busy", 32'(cmd_ready), 32'd0);
            check("done", 32'(done), 32'(k == exp_lv.size() - 1));
            if (k > 0 && button_out !== prev) tog++;
            prev = button_out;
            rec_q.push_back(button_out);
            if (queue_next && k == 2) begin
                cmd_valid   = 1'b1;
                cmd_level   = ~lvl;
                cmd_bounces = 3'd0;
            end
        end
        check("toggles", 32'(tog), 32'(2 * n));
        step();
        check("end_ready", 32'(cmd_ready), 32'd1);
        check("end_busy", 32'(busy), 32'd0);
        check("end_done", 32'(done), 32'd0);
        check("end_line", 32'(button_out), 32'(lvl));
        m_line = lvl;
    endtask

    initial begin
        int diffs, nb;
        logic lvl;

        do_reset(2);
        idle(50);

        // Clean press then clean release
        run_cmd(1'b1, 0, 1'b0, 1'b0);
        run_cmd(1'b0, 0, 1'b0, 1'b0);

        // Same 3-bounce press twice from reset must give the identical waveform
        do_reset(2);
        idle(50);
        run_cmd(1'b1, 3, 1'b0, 1'b0);
        rec1 = rec_q;
        do_reset(2);
        idle(50);
        run_cmd(1'b1, 3, 1'b0, 1'b0);
        check("repeat_len", 32'(rec_q.size()), 32'(rec1.size()));
        diffs = 0;
        for (int i = 0; i < rec1.size() && i < rec_q.size(); i++)
            if (rec1[i] !== rec_q[i]) diffs++;
        check("repeat_diff", 32'(diffs), 32'd0);

        // Clamped release from the pressed state (7 requested, BMAX pairs produced)
        run_cmd(1'b0, 7, 1'b0, 1'b0);

        // Request held while busy is ignored, then taken on the first ready cycle
        run_cmd(1'b1, 2, 1'b1, 1'b0);
        run_cmd(1'b0, 0, 1'b0, 1'b0);
        check("held_accept_wait", 32'(last_wait), 32'd0);

        // Reset during the first high-glitch of a press
        run_cmd(1'b1, 3, 1'b0, 1'b1);
        idle(3);

        for (int r = 0; r < 25; r++) begin
            lvl = 1'($urandom_range(0, 1));
            nb  = int'($urandom_range(0, 7));
            idle(int'($urandom_range(1, 4)));
            run_cmd(lvl, nb, 1'b0, (nb > 0) && ($urandom_range(0, 5) == 0));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

endmodule
